pixel_loader: RTL

PIXEL_LOADER -- requirements
Module: pixel_loader

---
 rtl/pixel_pkg.sv | 30 +++
 rtl/pixel_packer.sv | 129 ++++++++++++
 rtl/pixel_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared defaults and FSM state encoding for the pixel loader
//               (pixel_loader top and its pixel_packer sub-module).
// Contents    : c_PIX_W / c_LANES / c_ADDR_W parameter defaults,
//               c_CNT_W pixel-count width, state_t FSM enum, lane_w() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int c_PIX_W  = 16;   // bits per pixel
    localparam int c_LANES  = 3;    // pixels per SRAM word / write-enable lanes
    localparam int c_ADDR_W = 10;   // SRAM word address width
    localparam int c_CNT_W  = 12;   // width of the pixel_count request field

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a lane index; a single-lane build still needs one bit.
    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Lane bookkeeping for the pixel loader. Tracks which lane the
//               next pixel lands in, generates the active-low lane write
//               enables and drives the registered SRAM write data.
//               Build option PIXEL_LOADER_PACK_EN:
//                 defined   - pixels collect in a holding register; one write
//                             per full word, partial word written on flush.
//                 undefined - every pixel is written on its own cycle with a
//                             single lane enabled; flush writes nothing.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_clear         - restart at lane 0 (new load accepted)
//               i_push          - a pixel transfers this cycle
//               i_flush         - end of load, emit any partial word
//               i_pixel         - pixel data
//               o_write         - a write is issued at this clock edge
//               o_word_end      - this push fills the last lane of a word
//               o_sram_wean     - registered active-low lane write enables
//               o_sram_di       - registered SRAM write data
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int PIX_W = c_PIX_W,
    parameter int LANES = c_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_flush,
    input  logic [PIX_W-1:0]       i_pixel,
    output logic                   o_write,
    output logic                   o_word_end,
    output logic [LANES-1:0]       o_sram_wean,
    output logic [LANES*PIX_W-1:0] o_sram_di
);

    localparam int                  c_LANE_W    = lane_w(LANES);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(LANES - 1);

    logic [c_LANE_W-1:0] r_lane;
    logic                w_last_lane;

    assign w_last_lane = (r_lane == c_LAST_LANE);
    assign o_word_end  = i_push & w_last_lane;

    // Lane of the next pixel; restarts at every new load and after flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
        end else if (i_clear | i_flush) begin
            r_lane <= '0;
        end else if (i_push) begin
            r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
        end
    end

`ifdef PIXEL_LOADER_PACK_EN

    logic [LANES*PIX_W-1:0] r_hold;
    logic [LANES*PIX_W-1:0] w_word;
    logic [LANES-1:0]       w_fill;

    // Holding register with the incoming pixel merged into its lane, so a
    // word completed by this push can be written in the same edge.
    always_comb begin
        w_word = r_hold;
        w_word[r_lane*PIX_W +: PIX_W] = i_pixel;
    end

    // Lanes below the current index already hold a pixel of the open word.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_fill
        assign w_fill[gi] = (c_LANE_W'(gi) < r_lane);
    end

    assign o_write = (i_push & w_last_lane) | (i_flush & (r_lane != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            o_sram_wean <= '1;
            o_sram_di   <= '0;
        end else begin
            o_sram_wean <= '1;
            if (i_push) begin
                r_hold <= w_word;
            end
            if (i_push & w_last_lane) begin
                o_sram_wean <= '0;
                o_sram_di   <= w_word;
            end else if (i_flush & (r_lane != '0)) begin
                // Stale lanes of r_hold are masked off by the enables.
                o_sram_wean <= ~w_fill;
                o_sram_di   <= r_hold;
            end
        end
    end

`else

    logic [LANES-1:0] w_onehot;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_onehot
        assign w_onehot[gi] = (c_LANE_W'(gi) == r_lane);
    end

    assign o_write = i_push;

    // Only the targeted lane slice changes; the rest of the bus holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sram_wean <= '1;
            o_sram_di   <= '0;
        end else begin
            o_sram_wean <= '1;
            if (i_push) begin
                o_sram_wean                       <= ~w_onehot;
                o_sram_di[r_lane*PIX_W +: PIX_W]  <= i_pixel;
            end
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/pixel_loader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_loader
// Description : Streams pixel_count pixels from a valid/ready pixel input into
//               a LANES-pixel-wide SRAM starting at base_addr. Pixel k goes to
//               word base_addr + k/LANES (wrapping), lane k%LANES. All SRAM
//               outputs are registered.
//               Build option PIXEL_LOADER_PACK_EN (see pixel_packer) selects
//               whole-word packed writes instead of one write per pixel; the
//               final SRAM contents are the same either way.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - load request, honoured only when idle
//               base_addr     - first word address (sampled on start)
//               pixel_count   - pixels to load, 0..3072 (sampled on start)
//               pixel_in      - pixel data
//               pixel_valid   - pixel_in valid
//               pixel_ready   - loader accepts a pixel this cycle
//               sram_wean     - active-low lane write enables
//               sram_a        - SRAM word address
//               sram_di       - SRAM write data (lane i at [i*PIX_W +: PIX_W])
//               sram_oe       - output enable, held low
//               busy          - load in progress
//               done          - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_loader
    import pixel_pkg::*;
#(
    parameter int PIX_W  = c_PIX_W,
    parameter int LANES  = c_LANES,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [c_CNT_W-1:0]     pixel_count,
    input  logic [PIX_W-1:0]       pixel_in,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic [LANES-1:0]       sram_wean,
    output logic [ADDR_W-1:0]      sram_a,
    output logic [LANES*PIX_W-1:0] sram_di,
    output logic                   sram_oe,
    output logic                   busy,
    output logic                   done
);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_sram_a;
    logic [c_CNT_W-1:0] r_remaining;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;

    logic w_accept;
    logic w_push;
    logic w_flush;
    logic w_write;
    logic w_word_end;

    assign w_accept = (r_state == ST_IDLE) & start;
    assign w_push   = pixel_valid & r_ready;
    assign w_flush  = (r_state == ST_FLUSH);

    pixel_packer #(
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_push      (w_push),
        .i_flush     (w_flush),
        .i_pixel     (pixel_in),
        .o_write     (w_write),
        .o_word_end  (w_word_end),
        .o_sram_wean (sram_wean),
        .o_sram_di   (sram_di)
    );

    // FSM, word address counter and registered status outputs. The address
    // register r_addr always points at the word currently being filled;
    // sram_a captures it on the edge that issues a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_sram_a    <= '0;
            r_remaining <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_write) begin
                r_sram_a <= r_addr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= pixel_count;
                        r_busy      <= 1'b1;
                        if (pixel_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                            r_ready <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (w_push) begin
                        r_remaining <= r_remaining - 1'b1;
                        // Wraps modulo 2^ADDR_W by register width.
                        if (w_word_end) begin
                            r_addr <= r_addr + 1'b1;
                        end
                        if (r_remaining == c_CNT_W'(1)) begin
                            r_state <= ST_FLUSH;
                            r_ready <= 1'b0;
                        end
                    end
                end

                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_ready = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sram_a      = r_sram_a;
    assign sram_oe     = 1'b0;

endmodule
`default_nettype wire
